nios2_dct_trace_ctrl: RTL
=========================

// Module: nios2_dct_trace_ctrl
// PURPOSE
//  Sequencer for the OCI debug-capture trace (DCT) buffer. Packs narrow trace samples into a
//  30-bit frame and tracks the fill count. Hands full or flushed frames to the trace sink over a
//  valid/ready link. Drives the end-of-test flush that produces test_has_ended.
//  Sits between the CPU trace-sample source and the OCI test-bench/trace sink.
// PARAMETERS
//  SAMPLE_W  3   bits per trace sample
//  DEPTH     10  samples per frame; SAMPLE_W*DEPTH = 30 = dct_buffer width
//  TS_W      16  timestamp counter width (used only with the optional feature)
//  DROP_W    8   width of the saturating dropped-sample counter
// PORTS
//  clk             in   1          clock; all logic on rising edge
//  reset           in   1          synchronous, active-high reset
//  enable          in   1          capture enable
//  smp_valid       in   1          trace sample present this cycle (no backpressure)
//  smp_data        in   SAMPLE_W   trace sample
//  test_ending     in   1          pulse/level: request end-of-test flush
//  frm_valid       out  1          frame held in output register
//  frm_ready       in   1          sink accepts frame
//  dct_buffer      out  30         packed frame, sample k at [k*SAMPLE_W +: SAMPLE_W]
//  dct_count       out  4          valid samples in frame (1..DEPTH); 0 when frm_valid=0
//  frm_ts          out  TS_W       frame timestamp (port exists only with the optional feature)
//  test_has_ended  out  1          sticky: flush complete and sink drained
//  overflow        out  1          sticky: at least one sample dropped
//  drop_count      out  DROP_W     dropped samples, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0; accumulator, fill count and state cleared (state=IDLE). Reset mid-frame
//   discards the partial frame and any pending output frame.
//  Accumulator acc / acc_cnt: a sample is accepted when state==CAPTURE, enable=1, smp_valid=1 and
//   acc_cnt<DEPTH. Packing is LSB-first; unused upper bits of acc are 0.
//  Transfer: acc moves to the output register when acc_cnt==DEPTH (or FLUSH with acc_cnt>0) and
//   the slot is free (frm_valid=0, or frm_valid&frm_ready in the same cycle). acc_cnt then clears.
//   A sample arriving in the transfer cycle becomes sample 0 of the next frame.
//  Latency: the sample that completes a frame is visible on frm_valid/dct_buffer 1 cycle later.
//  Handshake: frm_valid, dct_buffer, dct_count and frm_ts stay stable until frm_ready=1. frm_valid
//   drops the cycle after acceptance unless a new transfer reloads the register the same cycle.
//  Drop: smp_valid=1 in CAPTURE with enable=1 and acc_cnt==DEPTH and no transfer possible drops
//   the sample. overflow sets; drop_count increments, saturating.
//  enable=0: no samples are accepted; the partial acc is retained and resumes appending when
//   enable returns. A full acc still transfers.
//  FSM:
//   IDLE       -> CAPTURE when enable=1; -> FLUSH on test_ending
//   CAPTURE    -> FLUSH on test_ending; a sample in the same cycle is accepted first and is
//                 included in the flush
//   FLUSH      -> transfer partial acc if acc_cnt>0 (waits for slot);
//                 then -> WAIT_DRAIN; if acc_cnt==0 -> WAIT_DRAIN directly
//   WAIT_DRAIN -> ENDED when frm_valid=0 (last frame accepted)
//   ENDED      test_has_ended=1; samples ignored (not counted as drops); leaves only on reset
//  Further test_ending pulses in FLUSH, WAIT_DRAIN or ENDED are ignored.
// CONFIGURATION
//  NIOS2_DCT_TIMESTAMP_EN defined:
//   - free-running TS_W counter, 0 at reset, wraps at 2^TS_W
//   - frm_ts = counter value in the transfer cycle
//  Not defined:
//   - no counter; frm_ts port absent
//   - all other behaviour identical
// TESTING
//  1. enable=1, 10 consecutive samples 3'b101 -> frm_valid next cycle, dct_buffer=30'h2DB6DB6D,
//     dct_count=10.
//  2. Samples 1,2,3 then test_ending, frm_ready=1 -> dct_buffer=30'h0D1, dct_count=3, then
//     test_has_ended=1; overflow=0.
//  3. frm_ready=0, 25 samples -> frame 1 held stable, acc fills at 20, 5 dropped: overflow=1,
//     drop_count=5; frm_ready=1 -> frame 2 follows next cycle.
//  4. Sample 7 and test_ending in the same cycle, acc_cnt=4 -> flushed frame dct_count=5,
//     top sample 3'b111.
//  5. Reset asserted mid-frame (acc_cnt=6, frm_valid=1) -> next cycle all outputs 0; 10 new
//     samples produce a clean frame with dct_count=10.
//  6. With NIOS2_DCT_TIMESTAMP_EN: frame transfers at cycles 100 and 65636 after reset ->
//     frm_ts=100, then frm_ts=100 (wrapped).

Source files
------------

// File: rtl/nios2_dct_trace_ctrl.sv
// nios2_dct_trace_ctrl: sequencer for the OCI debug-capture trace buffer.
// Packs SAMPLE_W-bit trace samples LSB-first into a DEPTH-sample frame, hands full or flushed
// frames to the trace sink over valid/ready, and runs the end-of-test flush.
//
// Optional feature: define NIOS2_DCT_TIMESTAMP_EN to add a free-running TS_W-bit counter whose
// value in the transfer cycle is presented on frm_ts alongside the frame.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            capture enable
//   smp_valid/data    trace sample input (no backpressure)
//   test_ending       request end-of-test flush
//   frm_valid/ready   output frame handshake
//   dct_buffer        packed frame, sample k at [k*SAMPLE_W +: SAMPLE_W]
//   dct_count         samples in the held frame, 0 when no frame is held
//   frm_ts            frame timestamp (optional feature only)
//   test_has_ended    sticky: flush complete and sink drained
//   overflow          sticky: at least one sample dropped
//   drop_count        saturating dropped-sample count
module nios2_dct_trace_ctrl #(
  parameter int unsigned SAMPLE_W = 3,
  parameter int unsigned DEPTH    = 10,
`ifdef NIOS2_DCT_TIMESTAMP_EN
  // Declared only where the timestamp counter exists.
  parameter int unsigned TS_W     = 16,
`endif
  parameter int unsigned DROP_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         smp_valid,
  input  logic [SAMPLE_W-1:0]          smp_data,
  input  logic                         test_ending,
  output logic                         frm_valid,
  input  logic                         frm_ready,
  output logic [SAMPLE_W*DEPTH-1:0]    dct_buffer,
  output logic [$clog2(DEPTH+1)-1:0]   dct_count,
`ifdef NIOS2_DCT_TIMESTAMP_EN
  output logic [TS_W-1:0]              frm_ts,
`endif
  output logic                         test_has_ended,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_count
);

  localparam int unsigned AccW = SAMPLE_W * DEPTH;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StCapture, StFlush, StWaitDrain, StEnded} state_e;

  state_e              state_q, state_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]     acc_cnt_q, acc_cnt_d;
  logic                frm_valid_q, frm_valid_d;
  logic [AccW-1:0]     frm_buf_q, frm_buf_d;
  logic [CntW-1:0]     frm_cnt_q, frm_cnt_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                slot_free, xfer, smp_live, accept, drop, complete;
  logic [AccW-1:0]     base_acc, grown_acc;
  logic [CntW-1:0]     base_cnt;
  logic [31:0]         shamt;

`ifdef NIOS2_DCT_TIMESTAMP_EN
  logic [TS_W-1:0]     ts_q, frm_ts_q, frm_ts_d;
`endif

  always_comb begin
    slot_free = !frm_valid_q || frm_ready;
    // Move the stored accumulator: full, or a partial one being flushed.
    xfer      = slot_free && ((acc_cnt_q == CntW'(DEPTH)) ||
                              ((state_q == StFlush) && (acc_cnt_q != '0)));
    // A sample arriving in a transfer cycle starts the next frame.
    base_acc  = xfer ? '0 : acc_q;
    base_cnt  = xfer ? '0 : acc_cnt_q;
    shamt     = 32'(base_cnt) * SAMPLE_W;
    grown_acc = base_acc | (AccW'(smp_data) << shamt);
    smp_live  = (state_q == StCapture) && enable && smp_valid;
    accept    = smp_live && (base_cnt < CntW'(DEPTH));
    drop      = smp_live && !accept;
    // The completing sample bypasses the accumulator so the frame appears one cycle later.
    complete  = accept && !xfer && slot_free && (base_cnt == CntW'(DEPTH - 1));

    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (xfer) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end
    if (accept) begin
      acc_d     = grown_acc;
      acc_cnt_d = base_cnt + CntW'(1);
    end
    if (complete) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end

    frm_valid_d = frm_valid_q;
    frm_buf_d   = frm_buf_q;
    frm_cnt_d   = frm_cnt_q;
`ifdef NIOS2_DCT_TIMESTAMP_EN
    frm_ts_d    = frm_ts_q;
`endif
    if (frm_valid_q && frm_ready) begin
      frm_valid_d = 1'b0;
      frm_buf_d   = '0;
      frm_cnt_d   = '0;
    end
    if (xfer || complete) begin
      frm_valid_d = 1'b1;
      frm_buf_d   = xfer ? acc_q : grown_acc;
      frm_cnt_d   = xfer ? acc_cnt_q : CntW'(DEPTH);
`ifdef NIOS2_DCT_TIMESTAMP_EN
      frm_ts_d    = ts_q;
`endif
    end

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (test_ending)  state_d = StFlush;
        else if (enable)  state_d = StCapture;
      end
      StCapture: begin
        if (test_ending)  state_d = StFlush;
      end
      StFlush: begin
        // Nothing is accepted here, so the accumulator only empties.
        if ((acc_cnt_q == '0) || xfer) state_d = StWaitDrain;
      end
      StWaitDrain: begin
        if (!frm_valid_q) state_d = StEnded;
      end
      StEnded:  state_d = StEnded;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      frm_valid_q <= 1'b0;
      frm_buf_q   <= '0;
      frm_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      frm_valid_q <= frm_valid_d;
      frm_buf_q   <= frm_buf_d;
      frm_cnt_q   <= frm_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef NIOS2_DCT_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      frm_ts_q <= '0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      frm_ts_q <= frm_ts_d;
    end
  end
  assign frm_ts = frm_ts_q;
`endif

  assign frm_valid      = frm_valid_q;
  assign dct_buffer     = frm_buf_q;
  assign dct_count      = frm_cnt_q;
  assign test_has_ended = (state_q == StEnded);
  assign overflow       = overflow_q;
  assign drop_count     = drop_cnt_q;

endmodule
